// File: rtl/opl_stats_pkg.sv
// opl_stats_pkg: counter indices, widths, OPL counter register map and poller FSM states.
package opl_stats_pkg;

    typedef enum logic [1:0] {PKTIN = 2'd0, PKTOUT, LUTHIT, LUTMISS} cnt_idx_t;

    localparam int NUM_CNT = 4;
    localparam int ACC_W   = 64;
    localparam int ERR_W   = 16;

    localparam logic [31:0] REG_PKTIN_ADDR   = 32'h0000_0000;
    localparam logic [31:0] REG_PKTOUT_ADDR  = 32'h0000_0004;
    localparam logic [31:0] REG_LUTHIT_ADDR  = 32'h0000_0008;
    localparam logic [31:0] REG_LUTMISS_ADDR = 32'h0000_000C;

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_ACC} state_t;

    function automatic logic [31:0] cnt_offset(cnt_idx_t i);
        return i == PKTIN  ? REG_PKTIN_ADDR  :
               i == PKTOUT ? REG_PKTOUT_ADDR :
               i == LUTHIT ? REG_LUTHIT_ADDR : REG_LUTMISS_ADDR;
    endfunction

endpackage

// File: rtl/opl_stats_poller_if.sv
// opl_stats_poller_if: AXI4-Lite read channels (AR/R) used by the stats poller.
interface opl_stats_poller_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] ARADDR;
    logic          ARVALID;
    logic          ARREADY;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;

    modport master (output ARADDR, ARVALID, RREADY, input ARREADY, RDATA, RRESP, RVALID);
    modport slave  (input ARADDR, ARVALID, RREADY, output ARREADY, RDATA, RRESP, RVALID);
endinterface

// File: rtl/opl_poll_timer.sv
// opl_poll_timer: free-running period counter, held at 0 while disabled; pulses o_start on wrap.
module opl_poll_timer #(
    parameter int PERIOD = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_enable,
    output logic o_start
);
    localparam int W = $clog2(PERIOD);

    logic [W-1:0] r_cnt;
    logic         w_wrap;

    assign w_wrap  = r_cnt == W'(PERIOD - 1);
    assign o_start = i_enable && w_wrap;

    always_ff @(posedge clk) begin
        if (!resetn || !i_enable || w_wrap)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/opl_stats_poller.sv
// opl_stats_poller: AXI4-Lite read master sweeping the four OPL clear-on-read counters into 64-bit totals.
// Define OPL_STATS_SNAPSHOT_EN for coherent shadow outputs plus a sweep_done pulse.
module opl_stats_poller
    import opl_stats_pkg::*;
#(
    parameter int          C_M_AXI_ADDR_WIDTH = 32,
    parameter int          C_M_AXI_DATA_WIDTH = 32,
    parameter logic [31:0] C_BASE_ADDRESS     = 32'h0,
    parameter int          C_POLL_PERIOD      = 1024
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               poll_now,
    opl_stats_poller_if.master m_axi,
    output logic [ACC_W-1:0]   acc_pktin,
    output logic [ACC_W-1:0]   acc_pktout,
    output logic [ACC_W-1:0]   acc_luthit,
    output logic [ACC_W-1:0]   acc_lutmiss,
    output logic               busy,
    output logic [ERR_W-1:0]   err_cnt
`ifdef OPL_STATS_SNAPSHOT_EN
    ,
    output logic               sweep_done
`endif
);
    state_t                        r_state, w_next;
    cnt_idx_t                      r_idx;
    logic                          r_pending;
    logic [C_M_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                    r_rresp;
    logic [ACC_W-1:0]              r_acc [NUM_CNT];
    logic                          w_tmr_start, w_req, w_go, w_last;

    opl_poll_timer #(.PERIOD(C_POLL_PERIOD)) u_timer (
        .clk      (clk),
        .resetn   (resetn),
        .i_enable (enable),
        .o_start  (w_tmr_start)
    );

    assign w_req  = w_tmr_start || poll_now;
    assign w_go   = w_req || r_pending;
    assign w_last = r_idx == LUTMISS;

    always_ff @(posedge clk) begin
        if (!resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_go ? S_AR : S_IDLE;
            S_AR:    w_next = m_axi.ARREADY ? S_R : S_AR;
            S_R:     w_next = m_axi.RVALID ? S_ACC : S_R;
            S_ACC:   w_next = w_last ? S_IDLE : S_AR;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        m_axi.ARVALID = r_state == S_AR;
        m_axi.RREADY  = r_state == S_R;
        m_axi.ARADDR  = r_state == S_AR ? C_M_AXI_ADDR_WIDTH'(C_BASE_ADDRESS | cnt_offset(r_idx)) : '0;
        busy          = r_state != S_IDLE;
    end

    // Requests arriving mid-sweep collapse into a single pending sweep.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_idx     <= PKTIN;
            r_pending <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            err_cnt   <= '0;
            for (int i = 0; i < NUM_CNT; i++)
                r_acc[i] <= '0;
        end else begin
            if (r_state == S_IDLE && w_go) begin
                r_idx     <= PKTIN;
                r_pending <= 1'b0;
            end else if (r_state != S_IDLE && w_req) begin
                r_pending <= 1'b1;
            end
            if (r_state == S_R && m_axi.RVALID) begin
                r_rdata <= m_axi.RDATA;
                r_rresp <= m_axi.RRESP;
            end
            if (r_state == S_ACC) begin
                if (r_rresp == 2'b00)
                    r_acc[r_idx] <= r_acc[r_idx] + ACC_W'(r_rdata);
                else if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
                if (!w_last)
                    r_idx <= cnt_idx_t'(r_idx + 2'd1);
            end
        end
    end

`ifdef OPL_STATS_SNAPSHOT_EN
    logic r_snap;

    assign sweep_done = r_snap;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_snap      <= 1'b0;
            acc_pktin   <= '0;
            acc_pktout  <= '0;
            acc_luthit  <= '0;
            acc_lutmiss <= '0;
        end else begin
            r_snap <= r_state == S_ACC && w_last;
            if (r_snap) begin
                acc_pktin   <= r_acc[PKTIN];
                acc_pktout  <= r_acc[PKTOUT];
                acc_luthit  <= r_acc[LUTHIT];
                acc_lutmiss <= r_acc[LUTMISS];
            end
        end
    end
`else
    assign acc_pktin   = r_acc[PKTIN];
    assign acc_pktout  = r_acc[PKTOUT];
    assign acc_luthit  = r_acc[LUTHIT];
    assign acc_lutmiss = r_acc[LUTMISS];
`endif
endmodule

// File: tb/tb_opl_stats_poller.sv
// tb_opl_stats_poller: directed bench with a delay-configurable AXI4-Lite read slave model.
module tb_opl_stats_poller;
    import opl_stats_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        poll_now = 1'b0;
    logic [63:0] acc_pktin, acc_pktout, acc_luthit, acc_lutmiss;
    logic        busy;
    logic [15:0] err_cnt;
`ifdef OPL_STATS_SNAPSHOT_EN
    logic        sweep_done;
`endif

    int          n_tests = 0;
    int          n_fail = 0;
    int          ar_dly = 0;
    int          r_dly = 0;
    bit          mon_en = 1'b0;
    logic [31:0] rd_data [4];
    logic [1:0]  rd_resp [4];

    opl_stats_poller_if #(.AW(32), .DW(32)) ax ();

    opl_stats_poller #(.C_POLL_PERIOD(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .poll_now    (poll_now),
        .m_axi       (ax),
        .acc_pktin   (acc_pktin),
        .acc_pktout  (acc_pktout),
        .acc_luthit  (acc_luthit),
        .acc_lutmiss (acc_lutmiss),
        .busy        (busy),
        .err_cnt     (err_cnt)
`ifdef OPL_STATS_SNAPSHOT_EN
        ,
        .sweep_done  (sweep_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_rd(input logic [31:0] d0, d1, d2, d3);
        rd_data[0] = d0; rd_data[1] = d1; rd_data[2] = d2; rd_data[3] = d3;
        for (int i = 0; i < 4; i++) rd_resp[i] = 2'b00;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic sweep(output int n);
        poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
        n = 0;
        while (busy && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_accs(input string tag, input logic [63:0] a, b, c, d);
        check({tag, "_pktin"},   acc_pktin,   a);
        check({tag, "_pktout"},  acc_pktout,  b);
        check({tag, "_luthit"},  acc_luthit,  c);
        check({tag, "_lutmiss"}, acc_lutmiss, d);
    endtask

    // Slave: inputs change on negedge; handshakes are judged from what the DUT saw at the posedge.
    initial begin
        logic        av_q, rr_q;
        logic [31:0] addr_q;
        bit          rpend;
        int          ac, rc, ridx;
        av_q = 1'b0; rr_q = 1'b0; addr_q = '0; rpend = 1'b0; ac = 0; rc = 0; ridx = 0;
        ax.ARREADY = 1'b0; ax.RVALID = 1'b0; ax.RDATA = '0; ax.RRESP = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rpend = 1'b0; ac = 0; rc = 0; av_q = 1'b0; rr_q = 1'b0;
                ax.ARREADY = 1'b0; ax.RVALID = 1'b0; ax.RDATA = '0; ax.RRESP = '0;
                continue;
            end
            if (mon_en && av_q && !ax.ARREADY) begin
                check("arvalid_hold", 64'(ax.ARVALID), 64'd1);
                check("araddr_hold", 64'(ax.ARADDR), 64'(addr_q));
            end
            if (av_q && ax.ARREADY) begin
                rpend = 1'b1;
                rc = 0;
                ridx = addr_q == REG_PKTOUT_ADDR  ? 1 :
                       addr_q == REG_LUTHIT_ADDR  ? 2 :
                       addr_q == REG_LUTMISS_ADDR ? 3 : 0;
            end
            if (rr_q && ax.RVALID) rpend = 1'b0;
            if (mon_en) check("rready_only_in_r", 64'(ax.RREADY), 64'(rpend));
            ac = ax.ARVALID ? ac + 1 : 0;
            ax.ARREADY = ax.ARVALID && ac > ar_dly;
            if (rpend) rc++;
            ax.RVALID = rpend && rc > r_dly;
            ax.RDATA  = ax.RVALID ? rd_data[ridx] : 32'h0;
            ax.RRESP  = ax.RVALID ? rd_resp[ridx] : 2'b00;
            av_q = ax.ARVALID; rr_q = ax.RREADY; addr_q = ax.ARADDR;
        end
    end

    initial begin
        int n;
        int rises [8];
        int nr;
        logic pb;
        set_rd(0, 0, 0, 0);
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_arvalid", 64'(ax.ARVALID), 0);
        check("rst_rready", 64'(ax.RREADY), 0);
        check("rst_araddr", 64'(ax.ARADDR), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_err", 64'(err_cnt), 0);
        check_accs("rst", 0, 0, 0, 0);
        resetn = 1'b1;
        @(negedge clk);

        set_rd(5, 6, 7, 8);
        sweep(n);
        check("t1_busy_cycles", 64'(n), 12);
        check_accs("t1", 5, 6, 7, 8);

        do_reset();
        set_rd(32'hFFFF_FFFF, 0, 0, 0);
        repeat (3) sweep(n);
        check_accs("t2", 64'h2_FFFF_FFFD, 0, 0, 0);

        set_rd(1, 2, 3, 4);
        ar_dly = 5; r_dly = 7; mon_en = 1'b1;
        sweep(n);
        mon_en = 1'b0; ar_dly = 0; r_dly = 0;
        check("t3_busy_cycles", 64'(n), 60);
        check_accs("t3", 64'h2_FFFF_FFFE, 2, 3, 4);

        do_reset();
        set_rd(1, 1, 9, 1);
        rd_resp[2] = 2'b10;
        sweep(n);
        check_accs("t4", 1, 1, 0, 1);
        check("t4_err", 64'(err_cnt), 1);

        do_reset();
        set_rd(1, 1, 1, 1);
        enable = 1'b1;
        nr = 0; pb = 1'b0;
        for (int k = 1; k <= 110; k++) begin
            @(negedge clk);
            if (busy && !pb && nr < 8) begin
                rises[nr] = k;
                nr++;
            end
            pb = busy;
            poll_now = k == 35;
        end
        enable = 1'b0;
        check("t5_sweep_count", 64'(nr), 4);
        check("t5_first_start", 64'(rises[0]), 32);
        check("t5_pending_start", 64'(rises[1]), 45);
        check("t5_periodic_2", 64'(rises[2]), 64);
        check("t5_periodic_3", 64'(rises[3]), 96);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        check_accs("t5", 4, 4, 4, 4);

        r_dly = 5;
        poll_now = 1'b1;
        @(negedge clk);
        poll_now = 1'b0;
        for (int i = 0; i < 50 && !ax.RREADY; i++) @(negedge clk);
        check("t6_in_r", 64'(ax.RREADY), 1);
        resetn = 1'b0;
        @(negedge clk);
        check("t6_arvalid", 64'(ax.ARVALID), 0);
        check("t6_rready", 64'(ax.RREADY), 0);
        check("t6_busy", 64'(busy), 0);
        check_accs("t6_rst", 0, 0, 0, 0);
        resetn = 1'b1;
        r_dly = 0;
        @(negedge clk);
        set_rd(5, 6, 7, 8);
        sweep(n);
        check("t6_busy_cycles", 64'(n), 12);
        check_accs("t6", 5, 6, 7, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
